// File: rtl/serial_byte_collector.sv
// Serial-to-byte collector: assembles accepted bits into bytes, with one pending slot
// behind a registered output slot, plus frame_start realignment and a sticky drop flag.
module serial_byte_collector #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       frame_start,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       partial_drop,
  input  logic       err_clr
);

  logic [7:0] sr_r;
  logic [2:0] idx_r;
  logic [7:0] pend_r;
  logic       pend_v_r;

  logic       accept_s;
  logic       xfer_s;
  logic       complete_s;
  logic       drop_s;
  logic [2:0] eff_idx_s;
  logic [2:0] pos_s;
  logic [7:0] merged_s;

  // Upstream is held off only when both slots are full; depends on registered state only.
  assign bit_ready = !pend_v_r;

  // Accept/transfer qualification, bit placement and the byte being completed this cycle.
  always_comb begin
    accept_s   = bit_valid && !pend_v_r;
    xfer_s     = byte_valid && byte_ready;
    eff_idx_s  = frame_start ? 3'd0 : idx_r;
    if (LSB_FIRST) begin
      pos_s = eff_idx_s;
    end else begin
      pos_s = 3'd7 - eff_idx_s;
    end
    // frame_start discards whatever partial bits the shift register holds.
    merged_s        = frame_start ? 8'h00 : sr_r;
    merged_s[pos_s] = bit_in;
    complete_s = accept_s && (eff_idx_s == 3'd7);
    drop_s     = accept_s && frame_start && (idx_r != 3'd0);
  end

  // Shift register and bit index advance on every accepted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r  <= 8'h00;
      idx_r <= 3'd0;
    end else if (accept_s) begin
      sr_r  <= complete_s ? 8'h00 : merged_s;
      idx_r <= eff_idx_s + 3'd1;
    end else begin
      sr_r  <= sr_r;
      idx_r <= idx_r;
    end
  end

  // Output/pending slot occupancy: EMPTY -> OUT -> OUT+PEND and back, in completion order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      pend_r     <= 8'h00;
      pend_v_r   <= 1'b0;
    end else if (complete_s) begin
      // A completion can only happen with pend empty, since bit_ready gates accepts.
      if (!byte_valid || xfer_s) begin
        byte_out   <= merged_s;
        byte_valid <= 1'b1;
      end else begin
        pend_r   <= merged_s;
        pend_v_r <= 1'b1;
      end
    end else if (xfer_s) begin
      if (pend_v_r) begin
        byte_out <= pend_r;
        pend_v_r <= 1'b0;
      end else begin
        byte_valid <= 1'b0;
      end
    end else begin
      byte_out   <= byte_out;
      byte_valid <= byte_valid;
    end
  end

  // Sticky drop flag; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial_drop <= 1'b0;
    end else if (drop_s) begin
      partial_drop <= 1'b1;
    end else if (err_clr) begin
      partial_drop <= 1'b0;
    end else begin
      partial_drop <= partial_drop;
    end
  end

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed self-checking bench for serial_byte_collector; runs an LSB-first and an
// MSB-first instance side by side on the same stimulus.
module tb_serial_byte_collector;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       frame_start;
  logic       byte_ready;
  logic       err_clr;
  logic       bit_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       partial_drop;
  logic       bit_ready_m;
  logic [7:0] byte_out_m;
  logic       byte_valid_m;
  logic       partial_drop_m;

  int n_checks = 0;
  int n_fail   = 0;

  serial_byte_collector #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .frame_start(frame_start), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .partial_drop(partial_drop), .err_clr(err_clr)
  );

  serial_byte_collector #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_m), .frame_start(frame_start), .byte_out(byte_out_m),
    .byte_valid(byte_valid_m), .byte_ready(byte_ready),
    .partial_drop(partial_drop_m), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Offers one bit and returns 1 time unit after the edge on which it was accepted.
  task automatic accept_bit(input logic b, input logic fs);
    int waited;
    waited = 0;
    bit_in = b; frame_start = fs; bit_valid = 1'b1;
    while (!bit_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bit_ready) begin
      check_eq("bit_ready_wait", {31'd0, bit_ready}, 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    bit_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) accept_bit(v[k], 1'b0);
  endtask

  // One-cycle byte_ready pulse; checks the byte on offer before taking it.
  task automatic take_byte(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, {31'd0, byte_valid}, 32'd1);
    check_eq({tag, "_data"}, {24'd0, byte_out}, {24'd0, exp});
    byte_ready = 1'b1;
    @(posedge clk); #1;
    byte_ready = 1'b0;
  endtask

  logic [7:0] stream_v;
  logic [7:0] model_v;
  logic       rb;

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    byte_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check_eq("rst_byte_out", {24'd0, byte_out}, 32'h00);
    check_eq("rst_partial_drop", {31'd0, partial_drop}, 32'd0);
    check_eq("rst_bit_ready", {31'd0, bit_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic assembly: bits 1,0,1,1,0,0,0,1 -> 8D LSB-first, B1 MSB-first.
    byte_ready = 1'b1;
    stream_v = 8'h8D;
    for (int k = 0; k < 7; k++) accept_bit(stream_v[k], 1'b0);
    check_eq("basic_not_early", {31'd0, byte_valid}, 32'd0);
    accept_bit(stream_v[7], 1'b0);
    check_eq("basic_valid", {31'd0, byte_valid}, 32'd1);
    check_eq("basic_lsb_data", {24'd0, byte_out}, 32'h8D);
    check_eq("basic_msb_data", {24'd0, byte_out_m}, 32'hB1);
    @(posedge clk); #1;
    check_eq("basic_one_cycle", {31'd0, byte_valid}, 32'd0);

    // Backpressure: FF to output, 00 to pending, then bit_ready drops.
    byte_ready = 1'b0;
    send_byte(8'hFF);
    check_eq("bp_ready_after_8", {31'd0, bit_ready}, 32'd1);
    for (int k = 0; k < 7; k++) accept_bit(1'b0, 1'b0);
    check_eq("bp_ready_after_15", {31'd0, bit_ready}, 32'd1);
    accept_bit(1'b0, 1'b0);
    check_eq("bp_ready_after_16", {31'd0, bit_ready}, 32'd0);
    @(posedge clk); #1;
    check_eq("bp_hold_ff", {24'd0, byte_out}, 32'hFF);
    take_byte("bp_first", 8'hFF);
    check_eq("bp_ready_back", {31'd0, bit_ready}, 32'd1);
    send_byte(8'h0F);
    check_eq("bp_ready_pend2", {31'd0, bit_ready}, 32'd0);
    take_byte("bp_second", 8'h00);
    take_byte("bp_third", 8'h0F);
    check_eq("bp_drained", {31'd0, byte_valid}, 32'd0);

    // Realignment: 3 bits, frame_start, 7 more -> one byte AA from the last 8 bits.
    byte_ready = 1'b1;
    for (int k = 0; k < 3; k++) accept_bit(1'b1, 1'b0);
    stream_v = 8'hAA;
    accept_bit(stream_v[0], 1'b1);
    check_eq("realign_drop_set", {31'd0, partial_drop}, 32'd1);
    check_eq("realign_no_byte", {31'd0, byte_valid}, 32'd0);
    for (int k = 1; k < 8; k++) accept_bit(stream_v[k], 1'b0);
    check_eq("realign_valid", {31'd0, byte_valid}, 32'd1);
    check_eq("realign_data", {24'd0, byte_out}, 32'hAA);
    @(posedge clk); #1;
    check_eq("realign_single", {31'd0, byte_valid}, 32'd0);
    check_eq("realign_drop_sticky", {31'd0, partial_drop}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check_eq("realign_err_clr", {31'd0, partial_drop}, 32'd0);

    // Reset mid-operation with both slots full, then again with a partial byte.
    byte_ready = 1'b0;
    send_byte(8'h3C);
    send_byte(8'h55);
    check_eq("mid_pend_full", {31'd0, bit_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
    check_eq("mid_rst_data", {24'd0, byte_out}, 32'h00);
    check_eq("mid_rst_ready", {31'd0, bit_ready}, 32'd1);
    check_eq("mid_rst_drop", {31'd0, partial_drop}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) accept_bit(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    byte_ready = 1'b1;
    send_byte(8'h96);
    check_eq("fresh_valid", {31'd0, byte_valid}, 32'd1);
    check_eq("fresh_data", {24'd0, byte_out}, 32'h96);
    check_eq("fresh_no_drop", {31'd0, partial_drop}, 32'd0);
    @(posedge clk); #1;

    // Sustained throughput: 64 random bits, back to back, byte_ready held high.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 8; k++) begin
        rb = 1'($urandom_range(1, 0));
        model_v[k] = rb;
        check_eq("sus_bit_ready", {31'd0, bit_ready}, 32'd1);
        accept_bit(rb, 1'b0);
      end
      check_eq("sus_valid", {31'd0, byte_valid}, 32'd1);
      check_eq("sus_lsb_data", {24'd0, byte_out}, {24'd0, model_v});
      check_eq("sus_msb_data", {24'd0, byte_out_m}, {24'd0, rev8(model_v)});
    end
    @(posedge clk); #1;
    check_eq("sus_drained", {31'd0, byte_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_byte_collector.md
# serial_byte_collector

Upstream feeder for the 8-bit population-count stage. It accepts a serial bit stream under a valid/ready handshake, assembles consecutive bits into 8-bit bytes, and presents each completed byte on a valid/ready output whose data bus connects directly to the counter's 8-bit input. One completed byte can be held waiting, so upstream is stalled only when both the output slot and the pending slot are occupied. A `frame_start` marker realigns byte boundaries, and any partial byte discarded by realignment is flagged.

## Interface
- `LSB_FIRST`, default 1. 1: the k-th accepted bit of a byte lands in `byte_out[k]`. 0: it lands in `byte_out[7-k]`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous active-low reset; release is synchronous to `clk` at the system level.
- `bit_in` input 1: serial data bit.
- `bit_valid` input 1: `bit_in` is valid this cycle.
- `bit_ready` output 1: collector can accept a bit this cycle. An accept is `bit_valid && bit_ready`.
- `frame_start` input 1: qualified by an accept; the accepted bit becomes bit index 0 of a new byte.
- `byte_out` output 8: assembled byte; feeds the population-count input.
- `byte_valid` output 1: `byte_out` holds a completed byte.
- `byte_ready` input 1: downstream takes the byte. A transfer is `byte_valid && byte_ready`.
- `partial_drop` output 1: sticky flag; a partial byte was discarded by `frame_start`.
- `err_clr` input 1: synchronous clear of `partial_drop`.

## Operation
- **State:**
  - shift register `sr[7:0]`
  - bit index `idx[2:0]`
  - pending register `pend[7:0]` with flag `pend_v`
  - output register `byte_out` with flag `byte_valid`
- **Bit placement on accept:** the effective index is `e = frame_start ? 0 : idx`. The bit is written to position `e` (LSB_FIRST=1) or `7-e` (LSB_FIRST=0) of the assembled value. Then `idx <= e+1`, which wraps 7→0.
- **Partial-byte drop:** if `frame_start` is set on an accept while `idx != 0`, the partially assembled bits are discarded and `partial_drop <= 1`. `frame_start` with `idx == 0` is not an error.
- **Byte completion:** an accept with `e == 7` completes a byte. The completed value is the `sr` contents with the current bit merged in.
  - Output slot free, or emptying this cycle via a transfer: load `byte_out`, set `byte_valid`.
  - Otherwise: load `pend`, set `pend_v`.
- **Output slot refill:** on a transfer with `pend_v == 1`, `byte_out <= pend` and `pend_v <= 0` on the same edge, so `byte_valid` stays 1.
- **Transfer with nothing queued:** on a transfer with no pending byte and no completion this cycle, `byte_valid <= 0`.
- **Backpressure:** `bit_ready = !pend_v`. It is combinational from registered state only and has no combinational path from `byte_ready`.
- **Ordering:** bytes leave in completion order. No byte is lost or duplicated.
- **Error flag priority:** `err_clr` clears `partial_drop`. If a new drop occurs in the same cycle, the set wins.
- **Sequencing:** no explicit FSM beyond `idx` and the occupancy states {EMPTY, OUT, OUT+PEND}. Transitions:
  - EMPTY→OUT on completion.
  - OUT→EMPTY on a transfer without completion.
  - OUT→OUT+PEND on a completion without a transfer.
  - OUT+PEND→OUT on a transfer.
  - Completion while in OUT+PEND is impossible because `bit_ready` is 0.

## Timing
- **Reset values** (asynchronous, while `rst_n` is low): `sr=0`, `idx=0`, `pend=0`, `pend_v=0`, `byte_out=8'h00`, `byte_valid=0`, `partial_drop=0`. Therefore `bit_ready=1`.
- **Latency:** the byte is visible on `byte_out`/`byte_valid` the cycle after the edge that accepted its 8th bit (1 cycle).
- **Throughput:** one bit per cycle sustained with `byte_ready` held at 1. `bit_ready` never drops in that case.
- **Data stability:** `byte_out` is stable while `byte_valid && !byte_ready`.
- **Reset mid-operation:** a partial byte, the pending byte, and the output byte are all discarded. No flag is raised.
- **Simultaneous completion and transfer with `pend_v=0`:** the new byte goes straight to `byte_out`, and `byte_valid` stays 1.

## Test plan
- **Basic assembly:** LSB_FIRST=1; stream bits 1,0,1,1,0,0,0,1 with `byte_ready=1` → `byte_out=8'h8D`, `byte_valid` high one cycle after the 8th accept, for exactly 1 cycle.
- **MSB-first ordering:** LSB_FIRST=0 with the same stream → `byte_out=8'hB1`.
- **Backpressure:** `byte_ready=0`; stream 24 bits of bytes 8'hFF, 8'h00, 8'h0F →
  - `bit_ready` falls after the 16th accept.
  - `byte_out` holds 8'hFF.
  - Then pulse `byte_ready` three times → 8'hFF, 8'h00, 8'h0F are delivered in order.
  - `bit_ready` returns to 1 the cycle after the first transfer.
- **Realignment:** 3 bits accepted, then `frame_start` with the next bit, then 7 more bits → exactly one byte is output, composed of the last 8 bits; `partial_drop=1`. A pulse on `err_clr` returns `partial_drop` to 0.
- **Reset mid-operation:** assert `rst_n=0` asynchronously mid-byte while a byte is pending → all outputs return to their reset values immediately. The next 8 bits form a fresh byte.
- **Sustained throughput:** 64 random bits with `byte_ready=1` → 8 bytes, `bit_ready` constantly 1, and each byte matches the reference model.
